// File: rtl/pong_pkg.sv
// Shared types and default geometry for the multi-ball Pong engine.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    SCORED    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int DEF_COORD_W       = 11;
  localparam int DEF_SCORE_W       = 4;
  localparam int DEF_WIN_SCORE     = 11;
  localparam int DEF_BALL_STEP     = 5;
  localparam int DEF_BALL_R        = 15;
  localparam int DEF_LEFT_BORDER   = 160;
  localparam int DEF_RIGHT_BORDER  = 1120;
  localparam int DEF_TOP_BORDER    = 128;
  localparam int DEF_BOTTOM_BORDER = 896;
  localparam int DEF_PADDLE_L_X    = 225;
  localparam int DEF_PADDLE_R_X    = 1030;
  localparam int DEF_PADDLE_W      = 25;
  localparam int DEF_PADDLE_H      = 125;
  localparam int DEF_CENTER_X      = 500;
  localparam int DEF_CENTER_Y      = 500;
  localparam int DEF_SERVE_DELAY   = 60;

  // Two guard bits above the widest supported coordinate keep every
  // "coordinate minus radius" test signed and free of underflow.
  localparam int MAX_COORD_W = 16;
  typedef logic signed [MAX_COORD_W+1:0] scoord_t;

  function automatic scoord_t widen(input int v);
    return scoord_t'(v);
  endfunction

endpackage

// File: rtl/pong_ball_core.sv
// One Pong game: serve/play/score/game-over FSM, ball physics and scores.
// Defining PONG_SPEED_RAMP_EN adds a per-game step that grows on paddle hits.
module pong_ball_core
  import pong_pkg::*;
#(
  parameter int COORD_W       = DEF_COORD_W,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int BALL_STEP     = DEF_BALL_STEP,
  parameter int BALL_R        = DEF_BALL_R,
  parameter int LEFT_BORDER   = DEF_LEFT_BORDER,
  parameter int RIGHT_BORDER  = DEF_RIGHT_BORDER,
  parameter int TOP_BORDER    = DEF_TOP_BORDER,
  parameter int BOTTOM_BORDER = DEF_BOTTOM_BORDER,
  parameter int PADDLE_L_X    = DEF_PADDLE_L_X,
  parameter int PADDLE_R_X    = DEF_PADDLE_R_X,
  parameter int PADDLE_W      = DEF_PADDLE_W,
  parameter int PADDLE_H      = DEF_PADDLE_H,
  parameter int CENTER_X      = DEF_CENTER_X,
  parameter int CENTER_Y      = DEF_CENTER_Y,
  parameter int SERVE_DELAY   = DEF_SERVE_DELAY
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_serve_req,
  input  logic [COORD_W-1:0] i_paddle_l_y,
  input  logic [COORD_W-1:0] i_paddle_r_y,
  output logic [COORD_W-1:0] o_ball_x,
  output logic [COORD_W-1:0] o_ball_y,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output game_state_t        o_game_state,
  output logic               o_point_pulse
);

  localparam int                 CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);
  localparam scoord_t            Y_MIN      = widen(TOP_BORDER + BALL_R);
  localparam scoord_t            Y_MAX      = widen(BOTTOM_BORDER - BALL_R);

  game_state_t        r_state, w_state_nxt;
  logic [COORD_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic               r_dx_pos, r_dy_pos, r_serve_dy_pos;
  logic               w_dx_nxt, w_dy_nxt, w_serve_dy_nxt;
  logic [SCORE_W-1:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_point, w_point_nxt;
  logic               w_serve;

  scoord_t w_x, w_y, w_pl_y, w_pr_y, w_step, w_mx, w_my;
  logic    w_top, w_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_dx_new, w_dy_new;

  assign w_x    = widen(int'(r_x));
  assign w_y    = widen(int'(r_y));
  assign w_pl_y = widen(int'(i_paddle_l_y));
  assign w_pr_y = widen(int'(i_paddle_r_y));

  assign w_top    = (w_y - widen(BALL_R)) <= widen(TOP_BORDER);
  assign w_bot    = (w_y + widen(BALL_R)) >= widen(BOTTOM_BORDER);
  assign w_hit_l  = !r_dx_pos && ((w_x - widen(BALL_R)) <= widen(PADDLE_L_X + PADDLE_W))
                    && (w_pl_y <= w_y) && (w_y < w_pl_y + widen(PADDLE_H));
  assign w_hit_r  = r_dx_pos && ((w_x + widen(BALL_R)) >= widen(PADDLE_R_X))
                    && (w_pr_y <= w_y) && (w_y < w_pr_y + widen(PADDLE_H));
  assign w_miss_l = (w_x - widen(BALL_R)) <= widen(LEFT_BORDER);
  assign w_miss_r = (w_x + widen(BALL_R)) >= widen(RIGHT_BORDER);

  assign w_dx_new = w_hit_l ? 1'b1 : (w_hit_r ? 1'b0 : r_dx_pos);
  assign w_dy_new = (w_top && !r_dy_pos) ? 1'b1 : ((w_bot && r_dy_pos) ? 1'b0 : r_dy_pos);
  assign w_mx     = w_x + (w_dx_new ? w_step : -w_step);

  always_comb begin
    w_my = w_y + (w_dy_new ? w_step : -w_step);
    if (w_my < Y_MIN)      w_my = Y_MIN;
    else if (w_my > Y_MAX) w_my = Y_MAX;
  end

`ifdef PONG_SPEED_RAMP_EN
  localparam int STEP_W = $clog2(2 * BALL_STEP + 1);
  logic [STEP_W-1:0] r_step, w_step_nxt;

  assign w_step = widen(int'(r_step));

  always_comb begin
    w_step_nxt = r_step;
    if (w_serve || w_point_nxt)
      w_step_nxt = STEP_W'(BALL_STEP);
    else if (r_state == PLAY && i_frame_tick && (w_hit_l || w_hit_r)
             && r_step < STEP_W'(2 * BALL_STEP))
      w_step_nxt = r_step + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_step <= STEP_W'(BALL_STEP);
    else         r_step <= w_step_nxt;
  end
`else
  assign w_step = widen(BALL_STEP);
`endif

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_dx_nxt       = r_dx_pos;
    w_dy_nxt       = r_dy_pos;
    w_serve_dy_nxt = r_serve_dy_pos;
    w_score_l_nxt  = r_score_l;
    w_score_r_nxt  = r_score_r;
    w_cnt_nxt      = r_cnt;
    w_point_nxt    = 1'b0;
    w_serve        = 1'b0;

    unique case (r_state)
      IDLE: w_serve = i_serve_req;
      GAME_OVER: begin
        if (i_serve_req) begin
          w_serve       = 1'b1;
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
          w_dx_nxt      = 1'b1;
        end
      end
      SCORED: begin
        if (i_frame_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_serve   = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (i_frame_tick) begin
          w_dy_nxt = w_dy_new;
          if (!w_hit_l && !w_hit_r && (w_miss_l || w_miss_r)) begin
            w_point_nxt = 1'b1;
            w_x_nxt     = COORD_W'(CENTER_X);
            w_y_nxt     = COORD_W'(CENTER_Y);
            w_cnt_nxt   = '0;
            // The next serve heads toward whoever conceded.
            w_dx_nxt    = !w_miss_l;
            if (w_miss_l) begin
              w_score_r_nxt = r_score_r + 1'b1;
              w_state_nxt   = (r_score_r == SCORE_LAST) ? GAME_OVER : SCORED;
            end else begin
              w_score_l_nxt = r_score_l + 1'b1;
              w_state_nxt   = (r_score_l == SCORE_LAST) ? GAME_OVER : SCORED;
            end
          end else begin
            w_dx_nxt = w_dx_new;
            w_x_nxt  = w_mx[COORD_W-1:0];
            w_y_nxt  = w_my[COORD_W-1:0];
          end
        end
      end
      default: ;
    endcase

    if (w_serve) begin
      w_state_nxt    = PLAY;
      w_dy_nxt       = r_serve_dy_pos;
      w_serve_dy_nxt = !r_serve_dy_pos;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_x            <= COORD_W'(CENTER_X);
      r_y            <= COORD_W'(CENTER_Y);
      r_dx_pos       <= 1'b1;
      r_dy_pos       <= 1'b0;
      r_serve_dy_pos <= 1'b0;
      r_score_l      <= '0;
      r_score_r      <= '0;
      r_cnt          <= '0;
      r_point        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state        <= w_state_nxt;
      r_x            <= w_x_nxt;
      r_y            <= w_y_nxt;
      r_dx_pos       <= w_dx_nxt;
      r_dy_pos       <= w_dy_nxt;
      r_serve_dy_pos <= w_serve_dy_nxt;
      r_score_l      <= w_score_l_nxt;
      r_score_r      <= w_score_r_nxt;
      r_cnt          <= w_cnt_nxt;
      r_point        <= w_point_nxt;
    end
  end

  assign o_ball_x      = r_x;
  assign o_ball_y      = r_y;
  assign o_score_l     = r_score_l;
  assign o_score_r     = r_score_r;
  assign o_game_state  = r_state;
  assign o_point_pulse = r_point;

endmodule

// File: rtl/pong_multi_ball_engine.sv
// NUM_GAMES independent Pong cores behind packed per-game ports.
// Optional feature macro: PONG_SPEED_RAMP_EN (ball speeds up on paddle hits).
module pong_multi_ball_engine
  import pong_pkg::*;
#(
  parameter int NUM_GAMES     = 2,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int BALL_STEP     = DEF_BALL_STEP,
  parameter int BALL_R        = DEF_BALL_R,
  parameter int LEFT_BORDER   = DEF_LEFT_BORDER,
  parameter int RIGHT_BORDER  = DEF_RIGHT_BORDER,
  parameter int TOP_BORDER    = DEF_TOP_BORDER,
  parameter int BOTTOM_BORDER = DEF_BOTTOM_BORDER,
  parameter int PADDLE_L_X    = DEF_PADDLE_L_X,
  parameter int PADDLE_R_X    = DEF_PADDLE_R_X,
  parameter int PADDLE_W      = DEF_PADDLE_W,
  parameter int PADDLE_H      = DEF_PADDLE_H,
  parameter int CENTER_X      = DEF_CENTER_X,
  parameter int CENTER_Y      = DEF_CENTER_Y,
  parameter int SERVE_DELAY   = DEF_SERVE_DELAY
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [NUM_GAMES*COORD_W-1:0]   paddle_l_y,
  input  logic [NUM_GAMES*COORD_W-1:0]   paddle_r_y,
  input  logic [NUM_GAMES-1:0]           serve_req,
  output logic [NUM_GAMES*COORD_W-1:0]   ball_x,
  output logic [NUM_GAMES*COORD_W-1:0]   ball_y,
  output logic [NUM_GAMES*SCORE_W-1:0]   score_l,
  output logic [NUM_GAMES*SCORE_W-1:0]   score_r,
  output logic [NUM_GAMES*2-1:0]         game_state,
  output logic [NUM_GAMES-1:0]           point_pulse
);

  for (genvar g = 0; g < NUM_GAMES; g++) begin : g_game
    game_state_t w_state;

    pong_ball_core #(
      .COORD_W      (COORD_W),
      .SCORE_W      (SCORE_W),
      .WIN_SCORE    (WIN_SCORE),
      .BALL_STEP    (BALL_STEP),
      .BALL_R       (BALL_R),
      .LEFT_BORDER  (LEFT_BORDER),
      .RIGHT_BORDER (RIGHT_BORDER),
      .TOP_BORDER   (TOP_BORDER),
      .BOTTOM_BORDER(BOTTOM_BORDER),
      .PADDLE_L_X   (PADDLE_L_X),
      .PADDLE_R_X   (PADDLE_R_X),
      .PADDLE_W     (PADDLE_W),
      .PADDLE_H     (PADDLE_H),
      .CENTER_X     (CENTER_X),
      .CENTER_Y     (CENTER_Y),
      .SERVE_DELAY  (SERVE_DELAY)
    ) u_core (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_frame_tick (frame_tick),
      .i_serve_req  (serve_req[g]),
      .i_paddle_l_y (paddle_l_y[g*COORD_W +: COORD_W]),
      .i_paddle_r_y (paddle_r_y[g*COORD_W +: COORD_W]),
      .o_ball_x     (ball_x[g*COORD_W +: COORD_W]),
      .o_ball_y     (ball_y[g*COORD_W +: COORD_W]),
      .o_score_l    (score_l[g*SCORE_W +: SCORE_W]),
      .o_score_r    (score_r[g*SCORE_W +: SCORE_W]),
      .o_game_state (w_state),
      .o_point_pulse(point_pulse[g])
    );

    assign game_state[g*2 +: 2] = w_state;
  end

endmodule

// File: tb/tb_pong_multi_ball_engine.sv
// Randomized scoreboard bench for pong_multi_ball_engine against a behavioural game model.
module tb_pong_multi_ball_engine;

  localparam int NG = 2, CW = 11, SW = 4, WIN = 11, STEP = 5, R = 15;
  localparam int LB = 160, RB = 1120, TOPB = 128, BOTB = 896;
  localparam int PLX = 225, PRX = 1030, PW = 25, PH = 125;
  localparam int CX = 500, CY = 500, SD = 60, FAR = 1500;
`ifdef PONG_SPEED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              frame_tick;
  logic [NG*CW-1:0]  paddle_l_y, paddle_r_y;
  logic [NG-1:0]     serve_req;
  logic [NG*CW-1:0]  ball_x, ball_y;
  logic [NG*SW-1:0]  score_l, score_r;
  logic [NG*2-1:0]   game_state;
  logic [NG-1:0]     point_pulse;

  pong_multi_ball_engine #(
    .NUM_GAMES(NG), .COORD_W(CW), .SCORE_W(SW), .WIN_SCORE(WIN), .BALL_STEP(STEP),
    .BALL_R(R), .LEFT_BORDER(LB), .RIGHT_BORDER(RB), .TOP_BORDER(TOPB),
    .BOTTOM_BORDER(BOTB), .PADDLE_L_X(PLX), .PADDLE_R_X(PRX), .PADDLE_W(PW),
    .PADDLE_H(PH), .CENTER_X(CX), .CENTER_Y(CY), .SERVE_DELAY(SD)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .serve_req(serve_req),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .game_state(game_state), .point_pulse(point_pulse)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: one entry per game, directions as +1/-1.
  int m_st[NG], m_x[NG], m_y[NG], m_dx[NG], m_dy[NG], m_sdy[NG];
  int m_sl[NG], m_sr[NG], m_cnt[NG], m_step[NG];
  bit m_pp[NG];

  typedef struct packed {
    logic [NG*CW-1:0] x, y;
    logic [NG*SW-1:0] sl, sr;
    logic [NG*2-1:0]  st;
    logic [NG-1:0]    pp;
  } snap_t;
  snap_t exp_q[$];

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      m_st[g] = 0; m_x[g] = CX; m_y[g] = CY; m_dx[g] = 1; m_dy[g] = -1; m_sdy[g] = -1;
      m_sl[g] = 0; m_sr[g] = 0; m_cnt[g] = 0; m_step[g] = STEP; m_pp[g] = 1'b0;
    end
  endtask

  task automatic serve_game(input int g);
    m_st[g] = 1; m_dy[g] = m_sdy[g]; m_sdy[g] = -m_sdy[g]; m_step[g] = STEP;
  endtask

  task automatic award(input int g, input bit left_missed);
    if (left_missed) begin m_sr[g]++; m_dx[g] = -1; end
    else begin m_sl[g]++; m_dx[g] = 1; end
    m_st[g] = (m_sl[g] == WIN || m_sr[g] == WIN) ? 3 : 2;
    m_pp[g] = 1'b1; m_x[g] = CX; m_y[g] = CY; m_cnt[g] = 0; m_step[g] = STEP;
  endtask

  task automatic play_tick(input int g);
    int x, y, ply, pry, s, ndx, ndy;
    bit hl, hr;
    x = m_x[g]; y = m_y[g]; s = m_step[g]; ndx = m_dx[g]; ndy = m_dy[g];
    ply = int'(paddle_l_y[g*CW +: CW]); pry = int'(paddle_r_y[g*CW +: CW]);
    if (y - R <= TOPB && ndy < 0) ndy = 1;
    else if (y + R >= BOTB && ndy > 0) ndy = -1;
    m_dy[g] = ndy;
    hl = m_dx[g] < 0 && x - R <= PLX + PW && ply <= y && y < ply + PH;
    hr = m_dx[g] > 0 && x + R >= PRX && pry <= y && y < pry + PH;
    if (hl || hr) begin
      ndx = hl ? 1 : -1;
      if (RAMP && m_step[g] < 2 * STEP) m_step[g]++;
    end else if (x - R <= LB) begin
      award(g, 1'b1); return;
    end else if (x + R >= RB) begin
      award(g, 1'b0); return;
    end
    m_dx[g] = ndx;
    m_x[g]  = x + s * ndx;
    y = y + s * ndy;
    if (y < TOPB + R) y = TOPB + R;
    if (y > BOTB - R) y = BOTB - R;
    m_y[g] = y;
  endtask

  task automatic model_game(input int g, input bit tick, input bit srv);
    m_pp[g] = 1'b0;
    case (m_st[g])
      0: if (srv) serve_game(g);
      3: if (srv) begin m_sl[g] = 0; m_sr[g] = 0; m_dx[g] = 1; serve_game(g); end
      2: if (tick) begin
           if (m_cnt[g] == SD - 1) begin m_cnt[g] = 0; serve_game(g); end
           else m_cnt[g]++;
         end
      default: if (tick) play_tick(g);
    endcase
  endtask

  function automatic snap_t snap();
    snap_t s;
    for (int g = 0; g < NG; g++) begin
      s.x[g*CW +: CW]  = CW'(m_x[g]);
      s.y[g*CW +: CW]  = CW'(m_y[g]);
      s.sl[g*SW +: SW] = SW'(m_sl[g]);
      s.sr[g*SW +: SW] = SW'(m_sr[g]);
      s.st[g*2 +: 2]   = 2'(m_st[g]);
      s.pp[g]          = m_pp[g];
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] pick_paddle(input int g);
    int r, v;
    r = int'($urandom_range(0, 99));
    if (r < 8)       v = m_y[g] - int'($urandom_range(0, PH - 1));
    else if (r < 28) v = int'($urandom_range(0, 1023));
    else             v = FAR;
    return CW'(v);
  endfunction

  task automatic drive_cycle(input bit tick, input logic [NG-1:0] srv, input bit rand_pad);
    @(negedge clock);
    frame_tick = tick;
    serve_req  = srv;
    for (int g = 0; g < NG; g++) begin
      paddle_l_y[g*CW +: CW] = rand_pad ? pick_paddle(g) : CW'(FAR);
      paddle_r_y[g*CW +: CW] = rand_pad ? pick_paddle(g) : CW'(FAR);
    end
    for (int g = 0; g < NG; g++) model_game(g, tick, srv[g]);
    if (tick || (|srv)) exp_q.push_back(snap());
  endtask

  function automatic logic [NG-1:0] idle_serves(input int pct);
    logic [NG-1:0] v;
    for (int g = 0; g < NG; g++)
      v[g] = (m_st[g] == 0 || m_st[g] == 3) && (int'($urandom_range(0, 99)) < pct);
    return v;
  endfunction

  // Monitor: outputs answer one clock after any tick or serve request.
  initial begin
    snap_t e;
    bit ev;
    forever begin
      @(posedge clock);
      ev = mon_en && (frame_tick || (|serve_req));
      #1;
      if (ev) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ball_x", ball_x, e.x);
          check("ball_y", ball_y, e.y);
          check("score_l", score_l, e.sl);
          check("score_r", score_r, e.sr);
          check("game_state", game_state, e.st);
          check("point_pulse", point_pulse, e.pp);
        end
      end else if (mon_en) begin
        check("point_pulse_idle", point_pulse, '0);
      end
    end
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; serve_req = '0;
    paddle_l_y = '0; paddle_r_y = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_ball_x", ball_x, {NG{CW'(CX)}});
    check("rst_ball_y", ball_y, {NG{CW'(CY)}});
    check("rst_score_l", score_l, '0);
    check("rst_score_r", score_r, '0);
    check("rst_state", game_state, '0);
    check("rst_point", point_pulse, '0);
    mon_en = 1'b1;

    // Serve game 0 only, then three ticks.
    drive_cycle(1'b0, 2'b01, 1'b0);
    repeat (3) drive_cycle(1'b1, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    check("serve_x0", ball_x[CW-1:0], 515);
    check("serve_y0", ball_y[CW-1:0], 485);
    check("idle_state1", game_state[3:2], 0);
    check("idle_x1", ball_x[2*CW-1:CW], 500);

    for (int c = 0; c < 25000; c++)
      drive_cycle($urandom_range(0, 3) != 0, idle_serves(15), 1'b1);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of play.
    drive_cycle(1'b0, idle_serves(100), 1'b0);
    repeat (4) drive_cycle(1'b1, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    mon_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async_rst_x", ball_x, {NG{CW'(CX)}});
    check("async_rst_y", ball_y, {NG{CW'(CY)}});
    check("async_rst_state", game_state, '0);
    check("async_rst_scores", {score_l, score_r}, '0);
    check("async_rst_point", point_pulse, '0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
